// File: rtl/compat_cache_pkg.sv
// Shared types and helpers for the multi-word direct-mapped core cache.
//   state_e       : controller states
//   calc_*_w      : address-field widths derived from SETS / WORDS_PER_LINE
//   byte_merge    : byte-enable masked 32-bit merge
package compat_cache_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOOKUP,
    FILL_REQ,
    FILL_WAIT,
    WR_REQ,
    WR_WAIT,
    BYP_REQ,
    RESP,
    FLUSH
  } state_e;

  function automatic int calc_index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int calc_off_w(input int words_per_line);
    return $clog2(words_per_line) + 2;
  endfunction

  function automatic int calc_tag_w(input int sets, input int words_per_line);
    return 32 - calc_index_w(sets) - calc_off_w(words_per_line);
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Line storage for the direct-mapped cache.
//   clk_i/rst_ni        : clock, async active-low reset (valid bits only)
//   rd_index_i/rd_word_i: combinational read of tag, valid and one data word
//   data_we_i, wr_*     : byte-enable write of one word of one line
//   tag_we_i/valid_set_i: tag update, optionally marking the line valid
//   valid_clr_i         : clear the valid bit at clr_index_i
module cache_line_store
  import compat_cache_pkg::*;
#(
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int INDEX_W        = 6,
  parameter int WORD_W         = 2,
  parameter int TAG_W          = 22
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [INDEX_W-1:0] rd_index_i,
  input  logic [WORD_W-1:0]  rd_word_i,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic               rd_valid_o,
  output logic [31:0]        rd_data_o,
  input  logic               data_we_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [WORD_W-1:0]  wr_word_i,
  input  logic [3:0]         wr_be_i,
  input  logic [31:0]        wr_data_i,
  input  logic               tag_we_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic               valid_set_i,
  input  logic               valid_clr_i,
  input  logic [INDEX_W-1:0] clr_index_i
);

  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS][WORDS_PER_LINE];
  logic [SETS-1:0]  valid_q;

  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i][rd_word_i];

  always_ff @(posedge clk_i) begin
    if (data_we_i) begin
      data_q[wr_index_i][wr_word_i] <= byte_merge(data_q[wr_index_i][wr_word_i], wr_data_i, wr_be_i);
    end
    if (tag_we_i) begin
      tag_q[wr_index_i] <= wr_tag_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      if (valid_clr_i) valid_q[clr_index_i] <= 1'b0;
      if (tag_we_i && valid_set_i) valid_q[wr_index_i] <= 1'b1;
    end
  end

endmodule

// File: rtl/compat_cache_lines.sv
// Direct-mapped, write-through, no-write-allocate cache with multi-word lines,
// placed between the core LSU (req/gnt/rvalid) and the memory bus.
//   clk, reset_n      : clock, async active-low reset
//   core_*            : core request in, gnt/rvalid/rdata/error out
//   mem_*             : single-outstanding memory request out, gnt/rvalid/rdata/error in
//   flush_i           : pulse to invalidate every line; flush_busy_o while it runs
//
// state     | meaning
// IDLE      | accept a core request, or start a pending flush
// LOOKUP    | tag compare on the latched address, pick the path
// FILL_REQ  | request fill word fill_cnt, held until gnt
// FILL_WAIT | wait for fill word, store it, advance or finish the line
// WR_REQ    | write-through request, held until gnt
// WR_WAIT   | wait for memory response of a write or bypass access
// BYP_REQ   | uncached access request, held until gnt
// RESP      | one-cycle core response
// FLUSH     | clear one valid bit per cycle over all sets
module compat_cache_lines
  import compat_cache_pkg::*;
#(
  parameter int          SETS           = 64,
  parameter int          WORDS_PER_LINE = 4,
  parameter logic [31:0] UNCACHED_BASE  = 32'h1A00_0000,
  parameter logic [31:0] UNCACHED_MASK  = 32'hFF00_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        core_req_i,
  input  logic [31:0] core_addr_i,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        core_error_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic        mem_error_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        flush_i,
  output logic        flush_busy_o
);

  localparam int INDEX_W = calc_index_w(SETS);
  localparam int OFF_W   = calc_off_w(WORDS_PER_LINE);
  localparam int TAG_W   = calc_tag_w(SETS, WORDS_PER_LINE);
  localparam int WORD_W  = (OFF_W > 2) ? OFF_W - 2 : 1;
  localparam logic [WORD_W-1:0]  LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);
  localparam logic [INDEX_W-1:0] LAST_SET  = INDEX_W'(SETS - 1);

  state_e              state_q;
  logic [31:0]         addr_q;
  logic                we_q;
  logic [3:0]          be_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                err_q;
  logic [WORD_W-1:0]   fill_cnt_q;
  logic [INDEX_W-1:0]  flush_cnt_q;
  logic                flush_pend_q;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [WORD_W-1:0]   req_word;
  logic [31:0]         fill_addr;
  logic                uncached;
  logic                hit;

  logic [TAG_W-1:0]    rd_tag;
  logic                rd_valid;
  logic [31:0]         rd_data;
  logic                data_we;
  logic [WORD_W-1:0]   wr_word;
  logic [3:0]          wr_be;
  logic [31:0]         wr_data;
  logic                tag_we;
  logic                valid_set;
  logic                valid_clr;
  logic [INDEX_W-1:0]  clr_index;

  assign req_tag   = addr_q[31 -: TAG_W];
  assign req_index = addr_q[OFF_W +: INDEX_W];

  // One-word lines have no word field; the word index is then constant zero.
  if (WORDS_PER_LINE > 1) begin : g_word
    assign req_word = addr_q[2 +: WORD_W];
  end else begin : g_noword
    assign req_word = '0;
  end

  assign fill_addr = {addr_q[31:OFF_W], {OFF_W{1'b0}}} | (32'(fill_cnt_q) << 2);
  assign uncached  = (addr_q & UNCACHED_MASK) == UNCACHED_BASE;
  assign hit       = rd_valid && (rd_tag == req_tag);

  cache_line_store #(
    .SETS          (SETS),
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .INDEX_W       (INDEX_W),
    .WORD_W        (WORD_W),
    .TAG_W         (TAG_W)
  ) u_store (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .rd_index_i (req_index),
    .rd_word_i  (req_word),
    .rd_tag_o   (rd_tag),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .data_we_i  (data_we),
    .wr_index_i (req_index),
    .wr_word_i  (wr_word),
    .wr_be_i    (wr_be),
    .wr_data_i  (wr_data),
    .tag_we_i   (tag_we),
    .wr_tag_i   (req_tag),
    .valid_set_i(valid_set),
    .valid_clr_i(valid_clr),
    .clr_index_i(clr_index)
  );

  always_comb begin
    data_we   = 1'b0;
    wr_word   = req_word;
    wr_be     = 4'h0;
    wr_data   = 32'h0;
    tag_we    = 1'b0;
    valid_set = 1'b0;
    valid_clr = 1'b0;
    clr_index = req_index;
    case (state_q)
      LOOKUP: begin
        if (!uncached) begin
          if (we_q && hit) begin
            data_we = 1'b1;
            wr_be   = be_q;
            wr_data = wdata_q;
          end else if (!we_q && !hit) begin
            // Line is rebuilt word by word; keep it invalid until complete.
            valid_clr = 1'b1;
          end
        end
      end
      FILL_WAIT: begin
        if (mem_rvalid_i) begin
          data_we = 1'b1;
          wr_word = fill_cnt_q;
          wr_be   = 4'hF;
          wr_data = mem_rdata_i;
          if (fill_cnt_q == LAST_WORD) begin
            tag_we    = 1'b1;
            valid_set = !(err_q || mem_error_i);
          end
        end
      end
      FLUSH: begin
        valid_clr = 1'b1;
        clr_index = flush_cnt_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    core_gnt_o    = (state_q == IDLE) && core_req_i && !flush_pend_q && !flush_i;
    core_rvalid_o = (state_q == RESP);
    core_rdata_o  = core_rvalid_o ? rdata_q : 32'h0;
    core_error_o  = core_rvalid_o && err_q;
    flush_busy_o  = (state_q == FLUSH);
    mem_req_o     = 1'b0;
    mem_addr_o    = 32'h0;
    mem_we_o      = 1'b0;
    mem_be_o      = 4'h0;
    mem_wdata_o   = 32'h0;
    if (state_q == FILL_REQ) begin
      mem_req_o  = 1'b1;
      mem_addr_o = fill_addr;
      mem_be_o   = 4'hF;
    end else if (state_q == WR_REQ || state_q == BYP_REQ) begin
      mem_req_o   = 1'b1;
      mem_addr_o  = {addr_q[31:2], 2'b00};
      mem_we_o    = we_q;
      mem_be_o    = be_q;
      mem_wdata_o = wdata_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= 32'h0;
      we_q         <= 1'b0;
      be_q         <= 4'h0;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
      fill_cnt_q   <= '0;
      flush_cnt_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      // A flush arriving mid-transaction waits until the response is out.
      if (flush_i && state_q != IDLE && state_q != FLUSH) flush_pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (flush_i || flush_pend_q) begin
            state_q <= FLUSH;
          end else if (core_req_i) begin
            addr_q     <= core_addr_i;
            we_q       <= core_we_i;
            be_q       <= core_be_i;
            wdata_q    <= core_wdata_i;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            fill_cnt_q <= '0;
            state_q    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (uncached) begin
            state_q <= BYP_REQ;
          end else if (we_q) begin
            state_q <= WR_REQ;
          end else if (hit) begin
            rdata_q <= rd_data;
            state_q <= RESP;
          end else begin
            state_q <= FILL_REQ;
          end
        end
        FILL_REQ: if (mem_gnt_i) state_q <= FILL_WAIT;
        FILL_WAIT: begin
          if (mem_rvalid_i) begin
            err_q <= err_q || mem_error_i;
            if (fill_cnt_q == req_word) rdata_q <= mem_rdata_i;
            if (fill_cnt_q == LAST_WORD) begin
              state_q <= RESP;
            end else begin
              fill_cnt_q <= fill_cnt_q + 1'b1;
              state_q    <= FILL_REQ;
            end
          end
        end
        WR_REQ, BYP_REQ: if (mem_gnt_i) state_q <= WR_WAIT;
        WR_WAIT: begin
          if (mem_rvalid_i) begin
            err_q <= err_q || mem_error_i;
            if (!we_q) rdata_q <= mem_rdata_i;
            state_q <= RESP;
          end
        end
        RESP: state_q <= IDLE;
        FLUSH: begin
          flush_cnt_q <= flush_cnt_q + 1'b1;
          if (flush_cnt_q == LAST_SET) begin
            flush_pend_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_compat_cache_lines.sv
module tb_compat_cache_lines;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        core_req_i = 1'b0;
  logic [31:0] core_addr_i = 32'h0;
  logic        core_we_i = 1'b0;
  logic [3:0]  core_be_i = 4'h0;
  logic [31:0] core_wdata_i = 32'h0;
  logic        core_gnt_o, core_rvalid_o, core_error_o;
  logic [31:0] core_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i = 1'b0;
  logic        mem_error_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        flush_i = 1'b0;
  logic        flush_busy_o;

  always #5 clk = ~clk;

  compat_cache_lines dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .core_req_i   (core_req_i),
    .core_addr_i  (core_addr_i),
    .core_we_i    (core_we_i),
    .core_be_i    (core_be_i),
    .core_wdata_i (core_wdata_i),
    .core_gnt_o   (core_gnt_o),
    .core_rvalid_o(core_rvalid_o),
    .core_rdata_o (core_rdata_o),
    .core_error_o (core_error_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_error_i  (mem_error_i),
    .mem_rdata_i  (mem_rdata_i),
    .flush_i      (flush_i),
    .flush_busy_o (flush_busy_o)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem_wr [logic [31:0]];
  int          stall_left = 0;
  int          txn_cnt = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [3:0]  last_wr_be = 4'h0;

  // Unwritten word at byte address a: word k above 0x100 holds 0xA000_0000+k.
  function automatic logic [31:0] mdef(input logic [31:0] a);
    return 32'hA000_0000 + ((a - 32'h100) >> 2);
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    logic [31:0] aw;
    aw = {a[31:2], 2'b00};
    if (mem_wr.exists(aw)) return mem_wr[aw];
    return mdef(aw);
  endfunction

  assign mem_gnt_i = mem_req_o && (stall_left == 0);

  always @(posedge clk) begin
    logic [31:0] old_w, new_w;
    mem_rvalid_i <= 1'b0;
    mem_error_i  <= 1'b0;
    mem_rdata_i  <= 32'h0;
    if (mem_req_o) begin
      if (stall_left > 0) begin
        stall_left <= stall_left - 1;
      end else begin
        txn_cnt      <= txn_cnt + 1;
        mem_rvalid_i <= 1'b1;
        mem_error_i  <= err_en && (mem_addr_o == err_addr);
        if (mem_we_o) begin
          old_w = mread(mem_addr_o);
          for (int b = 0; b < 4; b++)
            new_w[8*b +: 8] = mem_be_o[b] ? mem_wdata_o[8*b +: 8] : old_w[8*b +: 8];
          mem_wr[{mem_addr_o[31:2], 2'b00}] = new_w;
          last_wr_addr <= mem_addr_o;
          last_wr_be   <= mem_be_o;
        end else begin
          mem_rdata_i <= mread(mem_addr_o);
        end
      end
    end
  end

  // Address stability while a request waits for gnt.
  int          stall_seen = 0;
  int          stall_bad = 0;
  logic        prev_stalled = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  always @(negedge clk) begin
    if (mem_req_o && prev_stalled && mem_addr_o !== prev_addr) stall_bad++;
    if (mem_req_o && !mem_gnt_i) begin
      stall_seen++;
      prev_stalled = 1'b1;
      prev_addr    = mem_addr_o;
    end else begin
      prev_stalled = 1'b0;
    end
  end

  // ---------------- checking ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic access(input logic [31:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output int txns, output bit ok);
    int n;
    int base;
    ok = 1'b1;
    base = txn_cnt;
    @(negedge clk);
    core_req_i = 1'b1; core_addr_i = a; core_we_i = we; core_be_i = be; core_wdata_i = wd;
    #1;
    n = 0;
    while (!core_gnt_o && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!core_gnt_o) ok = 1'b0;
    @(negedge clk);
    core_req_i = 1'b0;
    lat = 1;
    while (!core_rvalid_o && lat < 400) begin
      @(negedge clk); lat++;
    end
    if (!core_rvalid_o) ok = 1'b0;
    rd   = core_rdata_o;
    er   = core_error_o;
    txns = txn_cnt - base;
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_txn;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, txns, busy_cnt, base;
    bit          ok;

    vecs[0]  = '{"cold_rd_104",   32'h104,  1'b0, 4'hF, 32'h0,        32'hA000_0001, 1'b0, 10, 4};
    vecs[1]  = '{"hit_rd_104",    32'h104,  1'b0, 4'hF, 32'h0,        32'hA000_0001, 1'b0, 2,  0};
    vecs[2]  = '{"hit_rd_10c",    32'h10C,  1'b0, 4'hF, 32'h0,        32'hA000_0003, 1'b0, 2,  0};
    vecs[3]  = '{"wr_hit_104",    32'h104,  1'b1, 4'b0010, 32'h0000_5500, 32'h0,     1'b0, 4,  1};
    vecs[4]  = '{"rd_merged_104", 32'h104,  1'b0, 4'hF, 32'h0,        32'hA000_5501, 1'b0, 2,  0};
    vecs[5]  = '{"wr_miss_2000",  32'h2000, 1'b1, 4'hF, 32'h1234_5678, 32'h0,        1'b0, 4,  1};
    vecs[6]  = '{"rd_fill_2000",  32'h2000, 1'b0, 4'hF, 32'h0,        32'h1234_5678, 1'b0, 10, 4};
    vecs[7]  = '{"byp_rd_1",      32'h1A00_0010, 1'b0, 4'hF, 32'h0,   mdef(32'h1A00_0010), 1'b0, 4, 1};
    vecs[8]  = '{"byp_rd_2",      32'h1A00_0010, 1'b0, 4'hF, 32'h0,   mdef(32'h1A00_0010), 1'b0, 4, 1};
    vecs[9]  = '{"conflict_504",  32'h504,  1'b0, 4'hF, 32'h0,        32'hA000_0101, 1'b0, 10, 4};
    vecs[10] = '{"refill_104",    32'h104,  1'b0, 4'hF, 32'h0,        32'hA000_5501, 1'b0, 10, 4};
    vecs[11] = '{"wr_hit_108",    32'h108,  1'b1, 4'b1001, 32'hAABB_CCDD, 32'h0,     1'b0, 4,  1};
    vecs[12] = '{"rd_merged_108", 32'h108,  1'b0, 4'hF, 32'h0,        32'hAA00_00DD, 1'b0, 2,  0};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_req",    {31'h0, mem_req_o},     32'h0);
    chk("rst_rvalid",     {31'h0, core_rvalid_o}, 32'h0);
    chk("rst_flush_busy", {31'h0, flush_busy_o},  32'h0);
    chk("rst_gnt",        {31'h0, core_gnt_o},    32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      access(vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata, rd, er, lat, txns, ok);
      chk({vecs[i].name, "_done"},  {31'h0, ok}, 32'h1);
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      chk({vecs[i].name, "_err"},   {31'h0, er}, {31'h0, vecs[i].exp_err});
      chk({vecs[i].name, "_lat"},   32'(lat), 32'(vecs[i].exp_lat));
      chk({vecs[i].name, "_txns"},  32'(txns), 32'(vecs[i].exp_txn));
      if (i == 3) begin
        chk("wr_fwd_addr", last_wr_addr, 32'h104);
        chk("wr_fwd_be",   {28'h0, last_wr_be}, 32'h2);
      end
      @(negedge clk);
      chk({vecs[i].name, "_rvalid_1cyc"}, {31'h0, core_rvalid_o}, 32'h0);
    end

    // gnt stalled for 5 cycles on the first fill word
    stall_seen = 0; stall_bad = 0; stall_left = 5;
    access(32'h304, 1'b0, 4'hF, 32'h0, rd, er, lat, txns, ok);
    chk("stall_done",  {31'h0, ok}, 32'h1);
    chk("stall_rdata", rd, 32'hA000_0081);
    chk("stall_lat",   32'(lat), 32'd15);
    chk("stall_txns",  32'(txns), 32'd4);
    chk("stall_cycles", 32'(stall_seen), 32'd5);
    chk("stall_addr_stable", 32'(stall_bad), 32'd0);

    // flush pulse during a miss: response first, then 64 flush cycles
    fork
      access(32'h704, 1'b0, 4'hF, 32'h0, rd, er, lat, txns, ok);
      begin
        repeat (4) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
      end
    join
    chk("flmiss_done",  {31'h0, ok}, 32'h1);
    chk("flmiss_rdata", rd, 32'hA000_0181);
    chk("flmiss_lat",   32'(lat), 32'd10);
    busy_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (flush_busy_o) busy_cnt++;
      else if (busy_cnt > 0) break;
    end
    chk("flush_busy_cycles", 32'(busy_cnt), 32'd64);
    access(32'h104, 1'b0, 4'hF, 32'h0, rd, er, lat, txns, ok);
    chk("postflush_txns",  32'(txns), 32'd4);
    chk("postflush_rdata", rd, 32'hA000_5501);

    // fill error on word 2 leaves the line invalid
    err_en = 1'b1; err_addr = 32'h118;
    access(32'h114, 1'b0, 4'hF, 32'h0, rd, er, lat, txns, ok);
    chk("fillerr_err",  {31'h0, er}, 32'h1);
    chk("fillerr_txns", 32'(txns), 32'd4);
    err_en = 1'b0;
    access(32'h114, 1'b0, 4'hF, 32'h0, rd, er, lat, txns, ok);
    chk("errrefill_txns",  32'(txns), 32'd4);
    chk("errrefill_err",   {31'h0, er}, 32'h0);
    chk("errrefill_rdata", rd, 32'hA000_0005);

    // reset in the middle of a fill burst
    base = txn_cnt;
    @(negedge clk);
    core_req_i = 1'b1; core_addr_i = 32'h904; core_we_i = 1'b0; core_be_i = 4'hF;
    #1;
    for (int i = 0; i < 20 && !core_gnt_o; i++) begin
      @(negedge clk); #1;
    end
    @(negedge clk);
    core_req_i = 1'b0;
    for (int i = 0; i < 40 && !(mem_req_o && txn_cnt == base + 2); i++) @(negedge clk);
    chk("midfill_req_seen", {31'h0, mem_req_o}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_mem_req", {31'h0, mem_req_o}, 32'h0);
    chk("rst_async_rvalid",  {31'h0, core_rvalid_o}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    access(32'h904, 1'b0, 4'hF, 32'h0, rd, er, lat, txns, ok);
    chk("postrst_txns",  32'(txns), 32'd4);
    chk("postrst_rdata", rd, 32'hA000_0201);
    access(32'h304, 1'b0, 4'hF, 32'h0, rd, er, lat, txns, ok);
    chk("postrst_invalid_txns", 32'(txns), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/compat_cache_lines.md
Name: compat_cache_lines

Overview:
- Parametrised successor to the single-word direct-mapped core cache; sits between the PULPino core LSU (OBI-style req/gnt/rvalid) and the CW305 memory bus.
- Direct-mapped, multi-word lines filled by a word burst; write-through with no write-allocate.
- Honours byte enables and the real memory gnt/rvalid handshake; adds an uncached address window and a sequential invalidate-all (flush).

Parameters:
- SETS, 64, number of lines (power of two, >=2); INDEX_W = log2(SETS)
- WORDS_PER_LINE, 4, 32-bit words per line (power of two, >=1); OFF_W = log2(WORDS_PER_LINE)+2; TAG_W = 32-INDEX_W-OFF_W
- UNCACHED_BASE, 32'h1A00_0000, base of the bypass window (peripherals)
- UNCACHED_MASK, 32'hFF00_0000, address bits compared against UNCACHED_BASE

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- core_req_i  in  1  core request
- core_addr_i  in  32  byte address (bits [1:0] ignored)
- core_we_i  in  1  1 = write
- core_be_i  in  4  byte enables
- core_wdata_i  in  32  write data
- core_gnt_o  out  1  request accepted this cycle
- core_rvalid_o  out  1  one-cycle response strobe
- core_rdata_o  out  32  read data, valid with rvalid
- core_error_o  out  1  error, valid with rvalid
- mem_req_o / mem_addr_o / mem_we_o / mem_be_o / mem_wdata_o  out  1/32/1/4/32  memory request
- mem_gnt_i / mem_rvalid_i / mem_error_i  in  1/1/1  memory handshake
- mem_rdata_i  in  32  memory read data
- flush_i  in  1  pulse: invalidate all lines
- flush_busy_o  out  1  flush in progress

Behaviour:
- Reset (async, reset_n=0): state IDLE; all valid bits 0; flush counter 0; flush-pending 0; all outputs 0. Tag/data arrays are not reset.
- Address split: tag = addr[31:INDEX_W+OFF_W], index = addr[INDEX_W+OFF_W-1:OFF_W], word = addr[OFF_W-1:2].
- States:
  - IDLE: core_gnt_o = core_req_i && !flush_pending && !flush_i. On grant, latch addr/we/be/wdata and go to LOOKUP. If flush_i or flush pending, go to FLUSH instead; flush has priority over a same-cycle core_req_i, which is not granted.
  - LOOKUP:
    - Uncached address ((addr & MASK) == BASE): go to BYP_REQ.
    - Read hit (valid && tag match): RESP with cached word.
    - Read miss: FILL_REQ; clear the line's valid bit.
    - Write hit: merge the enabled bytes into the cached word this cycle, then WR_REQ.
    - Write miss: WR_REQ, cache untouched.
  - FILL_REQ: mem_req_o=1, we=0, be=4'hF, addr = {tag,index,fill_cnt,2'b00}. mem_req_o is held, with address stable, until mem_gnt_i, then go to FILL_WAIT.
  - FILL_WAIT: on mem_rvalid_i, store mem_rdata_i at fill_cnt. If fill_cnt is the last word, write the tag, set valid (only if no error seen during the burst) and go to RESP. Otherwise increment fill_cnt and return to FILL_REQ. Exactly one outstanding memory transaction at any time.
  - WR_REQ / BYP_REQ: forward latched addr, we, be, wdata (word-aligned addr); hold until mem_gnt_i, then go to WR_WAIT.
  - WR_WAIT: on mem_rvalid_i, go to RESP. Bypass reads return mem_rdata_i.
  - RESP: core_rvalid_o=1 for exactly one cycle, then IDLE.
    - core_rdata_o: cache word for reads, mem word for bypass reads, 0 for writes.
    - core_error_o: OR of mem_error_i over the transaction.
  - FLUSH: clear valid[flush_cnt] each cycle; flush_busy_o=1. After SETS cycles (counter wraps to 0), go to IDLE and clear flush_pending.
- Latency:
  - Read hit: gnt in cycle T, rvalid in T+2.
  - Miss or write: rvalid one cycle after the final mem_rvalid_i.
- flush_i during an active transaction sets flush_pending; the flush runs after RESP. flush_i during FLUSH is absorbed.
- A fill error leaves the line invalid; core_error_o=1 with rvalid and rdata is undefined-but-stable (the stored word).
- mem_rvalid_i in IDLE, LOOKUP, FLUSH or *_REQ is ignored. This covers stale responses after reset.
- Reset mid-burst: mem_req_o drops immediately and the partial line stays invalid.

Decomposition:
- Package compat_cache_pkg holds:
  - state enum (IDLE, LOOKUP, FILL_REQ, FILL_WAIT, WR_REQ, WR_WAIT, BYP_REQ, RESP, FLUSH);
  - width-helper functions for INDEX_W/OFF_W/TAG_W;
  - a byte-merge function (be-masked 32-bit merge).
- Sub-module cache_line_store: tag array, valid flop vector with per-index clear, data array with word/byte-enable write port and combinational read.

Test Plan:
- Cold read 0x0000_0104, memory word k = 0xA000_0000+k: 4 fill reads at 0x100, 0x104, 0x108, 0x10C -> rdata 0xA000_0001. A repeat read gets rvalid 2 cycles after gnt with no mem_req_o.
- Write 0x0000_0104, be=4'b0010, wdata 0x0000_5500 after a fill -> mem write with be 0010 forwarded; a re-read returns 0xA000_5501 from cache.
- Write miss to 0x0000_2000 -> one mem write, then a read of 0x2000 triggers a fill (no allocate).
- mem_gnt_i held low for 5 cycles during a fill -> mem_req_o and mem_addr_o stable; the final rdata is still correct.
- Read 0x1A00_0010 (uncached) twice -> two memory reads, no fill. Then flush_i issued during a miss -> flush_busy_o high for 64 cycles after RESP, and the next read of 0x104 refills.
- mem_error_i on fill word 2 -> core_error_o=1 with rvalid; the next read of the same address refills. Asserting reset_n=0 mid-fill drops mem_req_o asynchronously.
